// File: rtl/stopwatch_bcd_counter.sv
//------------------------------------------------------------------------------
// Module      : stopwatch_bcd_counter
// Description : 1 s time base and BCD MM:SS counter with run/pause/clear/lap
//               control. The optional stop-at-limit check (DONE state) is built
//               only when STOPWATCH_LIMIT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  input  logic [15:0] limit_i,
  output logic [15:0] time_o,
  output logic [15:0] lap_o,
  output logic        running_o,
  output logic        limit_hit_o,
  output logic        wrap_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_LIMIT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;
`endif

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic            tick;
  logic [15:0]     next_time;

  // Ripple-carry BCD increment; digits saturate their compare with >= so a
  // corrupted digit still rolls back into range.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] n;
    n = t;
    if (t[3:0] < 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] < 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] < 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (t[15:12] < 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
          end
        end
      end
    end
    return n;
  endfunction

  assign tick      = (state == RUN) && (prescaler == PRE_MAX);
  assign next_time = bcd_inc(time_o);

`ifdef STOPWATCH_LIMIT_EN
  logic limit_hit;
  assign limit_hit = (limit_i != 16'h0000) && (next_time >= limit_i);
`else
  logic unused_limit;
  assign unused_limit = ^limit_i;
  assign limit_hit_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prescaler   <= '0;
      time_o      <= 16'h0000;
      lap_o       <= 16'h0000;
      running_o   <= 1'b0;
      wrap_o      <= 1'b0;
`ifdef STOPWATCH_LIMIT_EN
      limit_hit_o <= 1'b0;
`endif
    end else begin
      wrap_o <= 1'b0;
      if (clear_i) begin
        state       <= IDLE;
        prescaler   <= '0;
        time_o      <= 16'h0000;
        running_o   <= 1'b0;
`ifdef STOPWATCH_LIMIT_EN
        limit_hit_o <= 1'b0;
`endif
      end else begin
        // Lap samples the pre-tick time because time_o is still the old value.
        if (lap_i) begin
          lap_o <= time_o;
        end
        case (state)
          IDLE: begin
            prescaler <= '0;
            if (start_stop_i) begin
              state     <= RUN;
              running_o <= 1'b1;
            end
          end
          RUN: begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
              time_o <= next_time;
              wrap_o <= (next_time == 16'h0000);
            end
`ifdef STOPWATCH_LIMIT_EN
            if (tick && limit_hit) begin
              state       <= DONE;
              running_o   <= 1'b0;
              limit_hit_o <= 1'b1;
            end else
`endif
            if (start_stop_i) begin
              state     <= PAUSED;
              running_o <= 1'b0;
            end
          end
          PAUSED: begin
            if (start_stop_i) begin
              state     <= RUN;
              running_o <= 1'b1;
            end
          end
`ifdef STOPWATCH_LIMIT_EN
          DONE: begin
            prescaler <= '0;
          end
`endif
          default: begin
            state     <= IDLE;
            prescaler <= '0;
            running_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_bcd_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_stopwatch_bcd_counter
// Description : Table-driven bench for stopwatch_bcd_counter with TICK_DIV=4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        start_stop_i;
  logic        clear_i;
  logic        lap_i;
  logic [15:0] limit_i;
  logic [15:0] time_o;
  logic [15:0] lap_o;
  logic        running_o;
  logic        limit_hit_o;
  logic        wrap_o;

  stopwatch_bcd_counter #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_stop_i(start_stop_i),
    .clear_i     (clear_i),
    .lap_i       (lap_i),
    .limit_i     (limit_i),
    .time_o      (time_o),
    .lap_o       (lap_o),
    .running_o   (running_o),
    .limit_hit_o (limit_hit_o),
    .wrap_o      (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        clr;
    logic        lap;
    logic [15:0] limit;
    int          cycles;
    logic [15:0] t;
    logic [15:0] lp;
    logic        run;
    logic        hit;
    logic        wr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic ss, logic clr, logic lap, logic [15:0] limit,
                              int cycles, logic [15:0] t, logic [15:0] lp,
                              logic run, logic hit, logic wr);
    vec_t v;
    v.ss = ss; v.clr = clr; v.lap = lap; v.limit = limit; v.cycles = cycles;
    v.t = t; v.lp = lp; v.run = run; v.hit = hit; v.wr = wr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pulses are driven on the first cycle only; outputs checked 1 time unit
  // after the last active edge.
  task automatic apply(input vec_t v);
    vec_t e;
    sb.push_back(v);
    for (int i = 0; i < v.cycles; i++) begin
      @(negedge clk);
      start_stop_i = (i == 0) ? v.ss  : 1'b0;
      clear_i      = (i == 0) ? v.clr : 1'b0;
      lap_i        = (i == 0) ? v.lap : 1'b0;
      limit_i      = v.limit;
      @(posedge clk);
    end
    #1;
    start_stop_i = 1'b0;
    clear_i      = 1'b0;
    lap_i        = 1'b0;
    e = sb.pop_front();
    chk("time_o",      time_o,             e.t);
    chk("lap_o",       lap_o,              e.lp);
    chk("running_o",   {15'd0, running_o}, {15'd0, e.run});
    chk("limit_hit_o", {15'd0, limit_hit_o}, {15'd0, e.hit});
    chk("wrap_o",      {15'd0, wrap_o},    {15'd0, e.wr});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " time_o"},    time_o, 16'h0000);
    chk({nm, " lap_o"},     lap_o,  16'h0000);
    chk({nm, " running_o"}, {15'd0, running_o},   16'h0000);
    chk({nm, " limit_hit"}, {15'd0, limit_hit_o}, 16'h0000);
    chk({nm, " wrap_o"},    {15'd0, wrap_o},      16'h0000);
  endtask

  initial begin
    //             ss clr lap limit     cyc  time     lap      run hit wr
    tbl.push_back(mk(1, 0, 0, 16'h0000,  1, 16'h0000, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  4, 16'h0001, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  4, 16'h0002, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  1, 16'h0002, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000,  1, 16'h0002, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 10, 16'h0002, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000,  1, 16'h0002, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  1, 16'h0002, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  1, 16'h0003, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 36, 16'h0012, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  3, 16'h0012, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000,  1, 16'h0013, 16'h0012, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 16'h0000,  1, 16'h0000, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  5, 16'h0000, 16'h0012, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000,  1, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000,  9, 16'h0002, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h0000,  1, 16'h0002, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000,  1, 16'h0000, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  8, 16'h0000, 16'h0002, 0, 0, 0));
`ifdef STOPWATCH_LIMIT_EN
    tbl.push_back(mk(1, 0, 0, 16'h0005, 21, 16'h0005, 16'h0002, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0005,  5, 16'h0005, 16'h0002, 0, 1, 0));
`else
    tbl.push_back(mk(1, 0, 0, 16'h0005, 21, 16'h0005, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0005,  5, 16'h0005, 16'h0002, 0, 0, 0));
`endif
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 16'h0000, 16'h0002, 0, 0, 0));

    rst_n        = 1'b0;
    start_stop_i = 1'b0;
    clear_i      = 1'b0;
    lap_i        = 1'b0;
    limit_i      = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Digit roll 09:59 -> 10:00, then on to 59:59 -> 00:00 wrap.
    apply(mk(1, 0, 0, 16'h0000,     1, 16'h0000, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,  2396, 16'h0959, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,     4, 16'h1000, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000, 11988, 16'h5957, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,     4, 16'h5958, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,     4, 16'h5959, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,     4, 16'h0000, 16'h0002, 1, 0, 1));
    apply(mk(0, 0, 0, 16'h0000,     1, 16'h0000, 16'h0002, 1, 0, 0));
    apply(mk(0, 0, 0, 16'h0000,     7, 16'h0002, 16'h0002, 1, 0, 0));

    // Asynchronous reset between edges, mid-run.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 16'h0000, 8, 16'h0000, 16'h0000, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
